// File: rtl/regfile_pkg.sv
// Shared defaults, typedefs and constants for the multi-port architectural register file.
// The typedefs match the default (MIPS) geometry; parametrised instances size their own vectors.
package regfile_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int ARCH_DATA_W   = 32;
  localparam int ARCH_AW       = $clog2(NUM_ARCH_REGS);

  typedef logic [ARCH_AW-1:0]     reg_addr_t;
  typedef logic [ARCH_DATA_W-1:0] reg_data_t;

  localparam int unsigned ZERO_REG_IDX = 32'd0;
  localparam reg_addr_t   ZERO_REG     = reg_addr_t'(ZERO_REG_IDX);

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: reservations set busy, writebacks release it, flush clears all.
// Priority per register is rst > flush > reserve > write > hold; register 0 is never busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = NUM_ARCH_REGS,
  parameter  int NUM_WR   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_WR-1:0]    rsv_en,
  input  logic [NUM_WR*AW-1:0] rsv_addr,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  output logic [NUM_REGS-1:0]  busy
);

  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] set_s;
  logic [NUM_REGS-1:0] clr_s;
  logic [NUM_REGS-1:0] busy_nxt_s;

  // Decode reserve/release requests into per-register set and clear masks.
  always_comb begin
    set_s = '0;
    clr_s = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        set_s[r] = set_s[r] | (rsv_en[j] && (rsv_addr[j*AW +: AW] == AW'(r)));
        clr_s[r] = clr_s[r] | (wr_en[j]  && (wr_addr[j*AW +: AW]  == AW'(r)));
      end
    end
    set_s[ZERO_REG_IDX] = 1'b0;
    clr_s[ZERO_REG_IDX] = 1'b0;
  end

  // Reserve wins over release so a new producer supersedes the completing one.
  always_comb begin
    busy_nxt_s = busy_r;
    if (flush) begin
      busy_nxt_s = '0;
    end else begin
      busy_nxt_s = (busy_r & ~clr_s) | set_s;
    end
  end

  // Busy state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign busy = busy_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port architectural register file with same-cycle write-to-read bypass and a busy
// scoreboard; read ports return operand data plus a ready flag for issue-stage stalling.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = NUM_ARCH_REGS,
  parameter  int DATA_W   = ARCH_DATA_W,
  parameter  int NUM_RD   = 4,
  parameter  int NUM_WR   = 2,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        rsv_en,
  input  logic [NUM_WR*AW-1:0]     rsv_addr,
  input  logic                     flush
);

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_s;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy     (busy_s)
  );

  // Data array; later ports are applied last so the highest index wins a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG_IDX))) begin
          regs_r[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  logic [AW-1:0]     addr_s;
  logic              hit_s;
  logic [DATA_W-1:0] hit_data_s;

  // Read ports: zero register and idle ports read 0/ready, otherwise storage or bypass.
  always_comb begin
    rd_data    = '0;
    rd_ready   = '1;
    addr_s     = '0;
    hit_s      = 1'b0;
    hit_data_s = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      addr_s     = rd_addr[i*AW +: AW];
      hit_s      = 1'b0;
      hit_data_s = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        hit_data_s = (wr_en[j] && (wr_addr[j*AW +: AW] == addr_s)) ?
                     wr_data[j*DATA_W +: DATA_W] : hit_data_s;
        hit_s      = hit_s | (wr_en[j] && (wr_addr[j*AW +: AW] == addr_s));
      end
      if (!rd_en[i] || (addr_s == AW'(ZERO_REG_IDX))) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_ready[i]                 = 1'b1;
      end else if ((BYPASS != 0) && hit_s) begin
        rd_data[i*DATA_W +: DATA_W] = hit_data_s;
        rd_ready[i]                 = 1'b1;
      end else begin
        rd_data[i*DATA_W +: DATA_W] = regs_r[addr_s];
        rd_ready[i]                 = ~busy_s[addr_s];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed test of regfile_mp: one instance with bypass and one without, sharing all inputs,
// checked against hand-computed expected data/ready values.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic          clk;
  logic          rst;
  logic [3:0]    rd_en;
  logic [19:0]   rd_addr;
  logic [127:0]  rd_data_bp;
  logic [3:0]    rd_ready_bp;
  logic [127:0]  rd_data_nb;
  logic [3:0]    rd_ready_nb;
  logic [1:0]    wr_en;
  logic [9:0]    wr_addr;
  logic [63:0]   wr_data;
  logic [1:0]    rsv_en;
  logic [9:0]    rsv_addr;
  logic          flush;

  int n_cmp;
  int n_err;

  regfile_mp #(.BYPASS(1)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_bp), .rd_ready(rd_ready_bp),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
  );

  regfile_mp #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_ready(rd_ready_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Checks port p on both instances: bypass expectations (bd/br), no-bypass (nd/nr).
  task automatic chk_rd(input string tag, input int p,
                        input logic [31:0] bd, input logic br,
                        input logic [31:0] nd, input logic nr);
    check({tag, "/bp_data"}, rd_data_bp[p*32 +: 32], bd);
    check({tag, "/bp_rdy"},  {31'd0, rd_ready_bp[p]}, {31'd0, br});
    check({tag, "/nb_data"}, rd_data_nb[p*32 +: 32], nd);
    check({tag, "/nb_rdy"},  {31'd0, rd_ready_nb[p]}, {31'd0, nr});
  endtask

  task automatic idle();
    rd_en    = 4'd0;
    rd_addr  = 20'd0;
    wr_en    = 2'd0;
    wr_addr  = 10'd0;
    wr_data  = 64'd0;
    rsv_en   = 2'd0;
    rsv_addr = 10'd0;
    flush    = 1'b0;
  endtask

  task automatic set_rd(input int p, input reg_addr_t a);
    rd_en[p]          = 1'b1;
    rd_addr[p*5 +: 5] = a;
  endtask

  task automatic set_wr(input int p, input reg_addr_t a, input logic [31:0] d);
    wr_en[p]           = 1'b1;
    wr_addr[p*5 +: 5]  = a;
    wr_data[p*32 +: 32] = d;
  endtask

  task automatic set_rsv(input int p, input reg_addr_t a);
    rsv_en[p]          = 1'b1;
    rsv_addr[p*5 +: 5] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state on every port for every address.
    for (int a = 0; a < 32; a++) begin
      for (int p = 0; p < 4; p++) set_rd(p, reg_addr_t'(a));
      #1;
      for (int p = 0; p < 4; p++) chk_rd("reset", p, 32'd0, 1'b1, 32'd0, 1'b1);
    end

    // Write r5 with same-cycle read, then stored read; disabled port reads 0/ready.
    step(); idle();
    set_wr(0, 5'd5, 32'hDEADBEEF);
    set_rd(0, 5'd5);
    #1;
    chk_rd("wr5_same", 0, 32'hDEADBEEF, 1'b1, 32'd0, 1'b1);
    step(); idle();
    set_rd(1, 5'd5);
    rd_addr[15 +: 5] = 5'd5;
    #1;
    chk_rd("wr5_next", 1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1);
    chk_rd("rd_dis", 3, 32'd0, 1'b1, 32'd0, 1'b1);

    // Register 0 ignores writes and reservations.
    idle();
    set_wr(0, 5'd0, 32'h00001234);
    set_rsv(0, 5'd0);
    set_rd(1, 5'd0);
    #1;
    chk_rd("r0_same", 1, 32'd0, 1'b1, 32'd0, 1'b1);
    step(); idle();
    set_rd(1, 5'd0);
    #1;
    chk_rd("r0_next", 1, 32'd0, 1'b1, 32'd0, 1'b1);

    // Two write ports on r7: highest index wins for storage and bypass.
    idle();
    set_wr(0, 5'd7, 32'h00000011);
    set_wr(1, 5'd7, 32'h00000022);
    set_rd(2, 5'd7);
    #1;
    chk_rd("r7_same", 2, 32'h00000022, 1'b1, 32'd0, 1'b1);
    step(); idle();
    set_rd(2, 5'd7);
    #1;
    chk_rd("r7_next", 2, 32'h00000022, 1'b1, 32'h00000022, 1'b1);

    // Reserve r9: same-cycle read sees prior state, next cycle not ready; writeback releases.
    idle();
    set_rsv(1, 5'd9);
    set_rd(0, 5'd9);
    #1;
    chk_rd("rsv9_same", 0, 32'd0, 1'b1, 32'd0, 1'b1);
    step(); idle();
    set_rd(0, 5'd9);
    #1;
    chk_rd("rsv9_next", 0, 32'd0, 1'b0, 32'd0, 1'b0);
    set_wr(1, 5'd9, 32'h00000055);
    #1;
    chk_rd("wb9_same", 0, 32'h00000055, 1'b1, 32'd0, 1'b0);
    step(); idle();
    set_rd(0, 5'd9);
    #1;
    chk_rd("wb9_next", 0, 32'h00000055, 1'b1, 32'h00000055, 1'b1);

    // Reserve and write the same register: data commits, busy stays set.
    idle();
    set_rsv(0, 5'd10);
    set_wr(1, 5'd10, 32'h000000AA);
    step(); idle();
    set_rd(3, 5'd10);
    #1;
    chk_rd("rsvwr10", 3, 32'h000000AA, 1'b0, 32'h000000AA, 1'b0);

    // Reserve r3/r4, then flush with a reserve of r6 and a write of r3.
    idle();
    set_rsv(0, 5'd3);
    set_rsv(1, 5'd4);
    step(); idle();
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    #1;
    chk_rd("rsv3", 0, 32'd0, 1'b0, 32'd0, 1'b0);
    chk_rd("rsv4", 1, 32'd0, 1'b0, 32'd0, 1'b0);
    flush = 1'b1;
    set_rsv(0, 5'd6);
    set_wr(0, 5'd3, 32'h00000077);
    set_rd(2, 5'd6);
    #1;
    chk_rd("fl_r6_same", 2, 32'd0, 1'b1, 32'd0, 1'b1);
    chk_rd("fl_r3_same", 0, 32'h00000077, 1'b1, 32'd0, 1'b0);
    step(); idle();
    set_rd(0, 5'd3);
    set_rd(1, 5'd4);
    set_rd(2, 5'd6);
    set_rd(3, 5'd10);
    #1;
    chk_rd("fl_r3", 0, 32'h00000077, 1'b1, 32'h00000077, 1'b1);
    chk_rd("fl_r4", 1, 32'd0, 1'b1, 32'd0, 1'b1);
    chk_rd("fl_r6", 2, 32'd0, 1'b1, 32'd0, 1'b1);
    chk_rd("fl_r10", 3, 32'h000000AA, 1'b1, 32'h000000AA, 1'b1);

    // Reserve r11 so reset has busy state to clear; then reset alongside write/reserve/flush.
    idle();
    set_rsv(0, 5'd11);
    step(); idle();
    rst = 1'b1;
    flush = 1'b1;
    set_wr(0, 5'd12, 32'h00000099);
    set_rsv(1, 5'd13);
    step(); idle();
    rst = 1'b0;
    set_rd(0, 5'd5);
    set_rd(1, 5'd11);
    set_rd(2, 5'd12);
    set_rd(3, 5'd13);
    #1;
    chk_rd("rst_r5", 0, 32'd0, 1'b1, 32'd0, 1'b1);
    chk_rd("rst_r11", 1, 32'd0, 1'b1, 32'd0, 1'b1);
    chk_rd("rst_r12", 2, 32'd0, 1'b1, 32'd0, 1'b1);
    chk_rd("rst_r13", 3, 32'd0, 1'b1, 32'd0, 1'b1);
    idle();
    set_rd(0, 5'd7);
    set_rd(1, 5'd9);
    set_rd(2, 5'd3);
    set_rd(3, 5'd10);
    #1;
    chk_rd("rst_r7", 0, 32'd0, 1'b1, 32'd0, 1'b1);
    chk_rd("rst_r9", 1, 32'd0, 1'b1, 32'd0, 1'b1);
    chk_rd("rst_r3", 2, 32'd0, 1'b1, 32'd0, 1'b1);
    chk_rd("rst_r10", 3, 32'd0, 1'b1, 32'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
